// File: rtl/mult_div_unit_if.sv
// EX-stage handshake bundle for the HI/LO multiply/divide unit.
// master = EX pipeline side, slave = mult_div_unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mult_div_stall;
  logic             busy;
  logic [WIDTH-1:0] mf_result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, rs_val, rt_val,
    input  mult_div_stall, busy, mf_result, hi, lo
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val,
    output mult_div_stall, busy, mf_result, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 HI/LO multiply/divide unit (shift-add mult, restoring div).
// Optional MD_EARLY_OUT_EN: multiply finishes once the remaining multiplier is 0.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave md
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               is_div_q, is_div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;

  logic busy;
  logic op_in_range;
  logic accept;
  logic is_mul, is_dv, is_signed;
  logic rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign busy        = (state_q == RUN);
  assign op_in_range = (md.op >= OP_MULT) && (md.op <= OP_MFLO);
  assign accept      = md.op_valid && op_in_range && !busy;

  assign is_mul    = (md.op == OP_MULT) || (md.op == OP_MULTU);
  assign is_dv     = (md.op == OP_DIV) || (md.op == OP_DIVU);
  assign is_signed = (md.op == OP_MULT) || (md.op == OP_DIV);

  assign rs_neg = is_signed && md.rs_val[WIDTH-1];
  assign rt_neg = is_signed && md.rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -md.rs_val : md.rs_val;
  assign rt_mag = rt_neg ? -md.rt_val : md.rt_val;

  // One multiply step
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] prod_fix;
  logic               mul_early;

  assign acc_nx   = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign prod_fix = qneg_q ? -acc_nx : acc_nx;

`ifdef MD_EARLY_OUT_EN
  assign mul_early = ((mplier_q >> 1) == '0);
`else
  assign mul_early = 1'b0;
`endif

  // One restoring-divide step; sub fits WIDTH bits whenever sh >= divisor
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] sub;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, quot_nx;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign sh       = {rem_q, quot_q[WIDTH-1]};
  assign ge       = (sh >= {1'b0, dvsr_q});
  assign sub      = sh[WIDTH-1:0] - dvsr_q;
  assign rem_nx   = ge ? sub : sh[WIDTH-1:0];
  assign quot_nx  = {quot_q[WIDTH-2:0], ge};
  assign quot_fix = dz_q ? '1 : (qneg_q ? -quot_nx : quot_nx);
  assign rem_fix  = rneg_q ? -rem_nx : rem_nx;

  logic last;
  assign last = (cnt_q == CW'(1)) || (!is_div_q && mul_early);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul: begin
              state_d  = RUN;
              cnt_d    = CW'(WIDTH);
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, rs_mag};
              mplier_d = rt_mag;
              is_div_d = 1'b0;
              qneg_d   = rs_neg ^ rt_neg;
              rneg_d   = 1'b0;
              dz_d     = 1'b0;
            end
            is_dv: begin
              state_d  = RUN;
              cnt_d    = CW'(WIDTH);
              rem_d    = '0;
              quot_d   = rs_mag;
              dvsr_d   = rt_mag;
              is_div_d = 1'b1;
              qneg_d   = rs_neg ^ rt_neg;
              rneg_d   = rs_neg;
              dz_d     = (md.rt_val == '0);
            end
            (md.op == OP_MTHI): hi_d = md.rs_val;
            (md.op == OP_MTLO): lo_d = md.rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          rem_d  = rem_nx;
          quot_d = quot_nx;
        end else begin
          acc_d    = acc_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

  assign md.busy           = busy;
  assign md.mult_div_stall = md.op_valid && op_in_range && busy;
  assign md.hi             = hi_q;
  assign md.lo             = lo_q;
  assign md.mf_result      = (md.op == OP_MFHI) ? hi_q :
                             (md.op == OP_MFLO) ? lo_q : '0;

endmodule
